aes_round_iter: RTL and testbench

//  Iterative AES cipher core: one shared round datapath (SubBytes, ShiftRows,

---
 rtl/aes_round_iter.sv | 100 ++++++++++
 tb/tb_aes_round_iter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES encryption core, one shared round datapath reused Nr times.
module aes_round_iter #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int Nr = Nk + 6;
  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
    $error("aes_round_iter: Nk must be 4, 6 or 8");
  end
  localparam logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t         fsm, fsm_nxt;
  logic [3:0]   round, round_nxt;
  logic [127:0] state_reg, state_nxt, rnd_out;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic         last;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  assign last = round == 4'(Nr);
  // byte i = 4c+r; ShiftRows moves s[r][(c+r)%4] into s[r][c]
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign sb[i] = sbox[state_reg[127-8*i -: 8]];
    assign sr[i] = sb[4*(((i/4)+(i%4))%4) + i%4];
    assign rnd_out[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
  end
  always_comb begin
    fsm_nxt   = fsm;
    round_nxt = round;
    state_nxt = state_reg;
    case (fsm)
      IDLE: if (in_valid) begin
        fsm_nxt   = RUN;
        round_nxt = 4'd1;
        state_nxt = in_state ^ rk;
      end
      RUN: begin
        state_nxt = rnd_out;
        fsm_nxt   = last ? DONE : RUN;
        round_nxt = last ? round : round + 4'd1;
      end
      DONE: if (out_ready) begin
        fsm_nxt   = IDLE;
        round_nxt = '0;
      end
      default: fsm_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm       <= IDLE;
      round     <= '0;
      state_reg <= '0;
    end else begin
      fsm       <= fsm_nxt;
      round     <= round_nxt;
      state_reg <= state_nxt;
    end
  assign in_ready  = fsm == IDLE;
  assign busy      = fsm != IDLE;
  assign out_valid = fsm == DONE;
  assign rk_idx    = fsm == RUN ? round : 4'd0;
  assign out_state = state_reg;
endmodule

// File: tb/tb_aes_round_iter.sv
// tb_aes_round_iter: directed checks of aes_round_iter for Nk=4/6/8 against FIPS-197 / SP800-38A vectors.
module tb_aes_round_iter;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         iv [3];
  logic         ir [3];
  logic         ov [3];
  logic         ordy [3];
  logic         bsy [3];
  logic [127:0] ist [3];
  logic [127:0] ost [3];
  logic [127:0] rkv [3];
  logic [3:0]   idx [3];
  logic [127:0] ks [3][16];
  logic [7:0]   sbt [256];
  logic [127:0] bp [3];
  logic [127:0] be [3];
  int           acc [3];
  int           n_chk = 0;
  int           n_fail = 0;
  int           na, k, cyc;
  localparam logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_iter #(.Nk(4 + 2*g)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_state(ist[g]),
      .rk_idx(idx[g]), .rk(rkv[g]), .out_valid(ov[g]), .out_ready(ordy[g]),
      .out_state(ost[g]), .busy(bsy[g])
    );
    assign rkv[g] = ks[g][idx[g]];
  end
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int j = 0; j < 8; j++) begin
      if (b[j]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  // S-box built from the GF(2^8) inverse plus affine map, independent of any table
  task automatic build_sbox();
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sbt[x] = v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
    end
  endtask
  task automatic expand(input int d, input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) ks[d][r] = r <= nk + 6 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_block(input int d, input logic [127:0] p, input logic [127:0] exp, input int hold);
    int nr = 10 + 2*d;
    int c = 0;
    while (!ir[d] && c < 50) begin tick(); c++; end
    chk("in_ready before accept", 128'(ir[d]), 1);
    iv[d] = 1; ist[d] = p; ordy[d] = 0;
    tick();
    iv[d] = 0; ist[d] = ~p;
    chk("busy after accept", 128'(bsy[d]), 1);
    chk("in_ready in RUN", 128'(ir[d]), 0);
    c = 0;
    while (!ov[d] && c < 40) begin
      chk("rk_idx sweep", 128'(idx[d]), 128'(c + 1));
      tick(); c++;
    end
    chk("latency", 128'(c), 128'(nr));
    chk("ciphertext", ost[d], exp);
    chk("rk_idx in DONE", 128'(idx[d]), 0);
    for (int h = 0; h < hold; h++) begin
      iv[d] = 1; ist[d] = {4{$urandom}};
      tick();
      chk("held out_valid", 128'(ov[d]), 1);
      chk("held out_state", ost[d], exp);
      chk("in_ready while held", 128'(ir[d]), 0);
    end
    iv[d] = 0; ordy[d] = 1;
    tick();
    ordy[d] = 0;
    chk("out_valid after handshake", 128'(ov[d]), 0);
    chk("in_ready after handshake", 128'(ir[d]), 1);
    chk("busy after handshake", 128'(bsy[d]), 0);
    tick();
    chk("no second output", 128'(ov[d]), 0);
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin iv[d] = 0; ordy[d] = 0; ist[d] = 0; end
    build_sbox();
    expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      chk("reset in_ready", 128'(ir[d]), 1);
      chk("reset out_valid", 128'(ov[d]), 0);
      chk("reset busy", 128'(bsy[d]), 0);
      chk("reset out_state", ost[d], 0);
      chk("reset rk_idx", 128'(idx[d]), 0);
    end
    rst_n = 1;
    tick();
    run_block(0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    run_block(1, pt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0);
    run_block(2, pt, 128'h8ea2b7ca516745bfeafc49904b496089, 0);
    run_block(0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20);
    // abandon a block mid-flight with an asynchronous reset
    iv[0] = 1; ist[0] = pt; ordy[0] = 1;
    tick();
    iv[0] = 0;
    cyc = 0;
    while (idx[0] != 4'd5 && cyc < 20) begin tick(); cyc++; end
    chk("reached round 5", 128'(idx[0]), 5);
    #2 rst_n = 0;
    #1;
    chk("mid-op reset out_valid", 128'(ov[0]), 0);
    chk("mid-op reset busy", 128'(bsy[0]), 0);
    chk("mid-op reset out_state", ost[0], 0);
    chk("mid-op reset in_ready", 128'(ir[0]), 1);
    tick(); tick();
    rst_n = 1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (ov[0]) chk("no out_valid after abandon", 128'(ov[0]), 0);
    end
    ordy[0] = 0;
    run_block(0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    // back-to-back stream with in_valid held and out_ready tied high
    expand(0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    bp[0] = 128'h6bc1bee22e409f96e93d7e117393172a; be[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    bp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; be[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    bp[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; be[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    for (int j = 0; j < 3; j++) acc[j] = 0;
    na = 0; k = 0; cyc = 0;
    ordy[0] = 1; iv[0] = 1; ist[0] = bp[0];
    while (k < 3 && cyc < 100) begin
      if (ir[0] && na < 3) begin acc[na] = cyc; na++; end
      if (ov[0]) begin
        chk("b2b ciphertext", ost[0], be[k]);
        k++;
        if (k < 3) ist[0] = bp[k];
        else iv[0] = 0;
      end
      tick(); cyc++;
    end
    iv[0] = 0;
    chk("b2b blocks done", 128'(k), 3);
    chk("b2b accept spacing 1", 128'(acc[1] - acc[0]), 12);
    chk("b2b accept spacing 2", 128'(acc[2] - acc[1]), 12);
    tick();
    ordy[0] = 0;
    chk("b2b idle after stream", 128'(ir[0]), 1);
    chk("b2b no extra output", 128'(ov[0]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
